// File: rtl/display_pkg.sv
// Shared types and segment encodings for the hex display controller.
// Segments are {g,f,e,d,c,b,a}, active low.
package display_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_0     = 7'h40;
   localparam seg_t SEG_1     = 7'h79;
   localparam seg_t SEG_2     = 7'h24;
   localparam seg_t SEG_3     = 7'h30;
   localparam seg_t SEG_4     = 7'h19;
   localparam seg_t SEG_5     = 7'h12;
   localparam seg_t SEG_6     = 7'h02;
   localparam seg_t SEG_7     = 7'h78;
   localparam seg_t SEG_8     = 7'h00;
   localparam seg_t SEG_9     = 7'h10;
   localparam seg_t SEG_A     = 7'h08;
   localparam seg_t SEG_B     = 7'h03;
   localparam seg_t SEG_C     = 7'h46;
   localparam seg_t SEG_D     = 7'h21;
   localparam seg_t SEG_E     = 7'h06;
   localparam seg_t SEG_F     = 7'h0E;
   localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] hex_i,
   output seg_t       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      unique case (hex_i)
         4'h0: seg_o = SEG_0;
         4'h1: seg_o = SEG_1;
         4'h2: seg_o = SEG_2;
         4'h3: seg_o = SEG_3;
         4'h4: seg_o = SEG_4;
         4'h5: seg_o = SEG_5;
         4'h6: seg_o = SEG_6;
         4'h7: seg_o = SEG_7;
         4'h8: seg_o = SEG_8;
         4'h9: seg_o = SEG_9;
         4'hA: seg_o = SEG_A;
         4'hB: seg_o = SEG_B;
         4'hC: seg_o = SEG_C;
         4'hD: seg_o = SEG_D;
         4'hE: seg_o = SEG_E;
         4'hF: seg_o = SEG_F;
      endcase
   end

endmodule

// File: rtl/hex_display_ctrl.sv
// Multiplexed common-anode hex display driver with a frame-synchronous double
// buffer so the shown value never tears mid-scan.
module hex_display_ctrl
   import display_pkg::*;
#(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [31:0]       data_i,
   input  logic              update_i,
   input  logic              blank_lz_i,
   output logic [DIGITS-1:0] an_o,
   output logic [6:0]        seg_o,
   output logic              dp_o
);

   localparam int unsigned PrescW   = $clog2(REFRESH_DIV);
   localparam int unsigned IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned DataW    = 4 * DIGITS;
   localparam logic [31:0] DataMask = 32'hFFFF_FFFF >> (32 - DataW);

   logic [PrescW-1:0] presc_q, presc_d;
   logic [IdxW-1:0]   idx_q, idx_d;
   logic [31:0]       shadow_q, shadow_d;
   logic [31:0]       disp_q, disp_d;
   logic [DIGITS-1:0] an_q, an_d;
   seg_t              seg_q, seg_d;

   logic        tick;
   logic        frame_end;
   logic [31:0] data_masked;
   logic [3:0]  nibble;
   logic [31:0] upper;
   logic        blank;
   seg_t        seg_dec;

   assign data_masked = data_i & DataMask;
   assign tick        = (presc_q == PrescW'(REFRESH_DIV - 1));
   assign frame_end   = tick && (idx_q == IdxW'(DIGITS - 1));

   always_comb begin
      presc_d  = tick ? '0 : presc_q + PrescW'(1);
      idx_d    = idx_q;
      if (tick) begin
         idx_d = frame_end ? '0 : idx_q + IdxW'(1);
      end
      shadow_d = update_i ? data_masked : shadow_q;
      disp_d   = disp_q;
      // Bypass the shadow so a strobe landing on frame_end is not lost a frame.
      if (frame_end) begin
         disp_d = update_i ? data_masked : shadow_q;
      end
   end

   // Digit-select mux and leading-zero detection for the currently scanned digit.
   always_comb begin
      nibble = disp_q[{idx_q, 2'b00} +: 4];
      upper  = disp_q >> {idx_q, 2'b00};
      blank  = blank_lz_i && (idx_q != '0) && (upper == 32'd0);
   end

   hex_to_7seg u_hex_to_7seg (
      .hex_i (nibble),
      .seg_o (seg_dec)
   );

   always_comb begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = blank ? SEG_BLANK : seg_dec;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         disp_q   <= '0;
         an_q     <= '1;
         seg_q    <= SEG_BLANK;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign an_o  = an_q;
   assign seg_o = seg_q;
   assign dp_o  = 1'b1;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl: a cycle-count based reference model
// checked every cycle, plus directed literal checks of the scan and buffering.
module tb_hex_display_ctrl;

   localparam int unsigned DIGITS = 8;
   localparam int unsigned RDIV   = 4;
   localparam int unsigned FRAME  = DIGITS * RDIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] data = 32'd0;
   logic        update = 1'b0;
   logic        blz = 1'b0;
   logic [7:0]  an_o;
   logic [6:0]  seg_o;
   logic        dp_o;

   int n_checks = 0;
   int n_fail   = 0;

   hex_display_ctrl #(
      .DIGITS      (DIGITS),
      .REFRESH_DIV (RDIV)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .data_i     (data),
      .update_i   (update),
      .blank_lz_i (blz),
      .an_o       (an_o),
      .seg_o      (seg_o),
      .dp_o       (dp_o)
   );

   always #5 clk = ~clk;

   logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   function automatic logic [6:0] model_seg(input logic [31:0] v, input int k, input logic b);
      logic [31:0] up;
      up = v >> (4 * k);
      if (k > 0 && b && up == 32'd0) return 7'h7F;
      return hex_tab[up[3:0]];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position in the scan follows directly from cycles since reset.
   int unsigned cyc = 0;
   logic [31:0] m_shadow = 32'd0;
   logic [31:0] m_disp = 32'd0;
   logic [7:0]  exp_an = 8'hFF;
   logic [6:0]  exp_seg = 7'h7F;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc      = 0;
         m_shadow = 32'd0;
         m_disp   = 32'd0;
         exp_an   = 8'hFF;
         exp_seg  = 7'h7F;
      end else begin
         int digit;
         digit   = int'((cyc / RDIV) % DIGITS);
         exp_an  = ~(8'h01 << digit);
         exp_seg = model_seg(m_disp, digit, blz);
         if ((cyc % FRAME) == FRAME - 1) m_disp = update ? data : m_shadow;
         if (update) m_shadow = data;
         cyc++;
      end
   end

   always @(negedge clk) begin
      chk("model_an", {24'd0, an_o}, {24'd0, exp_an});
      chk("model_seg", {25'd0, seg_o}, {25'd0, exp_seg});
      chk("model_dp", {31'd0, dp_o}, 32'd1);
   end

   task automatic wait_an(input logic [7:0] target, input string name);
      for (int i = 0; i < 100 && an_o !== target; i++) @(negedge clk);
      chk(name, {24'd0, an_o}, {24'd0, target});
   endtask

   task automatic load(input logic [31:0] v);
      @(negedge clk);
      data   = v;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      repeat (2 * FRAME) @(negedge clk);
   endtask

   task automatic check_digit(input int k, input logic [6:0] exp, input string name);
      logic [7:0] a;
      a = ~(8'h01 << k);
      wait_an(a, {name, "_an"});
      chk(name, {25'd0, seg_o}, {25'd0, exp});
   endtask

   logic [6:0] exp_val [8] = '{7'h0E, 7'h46, 7'h03, 7'h08, 7'h30, 7'h24, 7'h79, 7'h40};

   initial begin
      // 1. Reset and first frame
      repeat (3) @(negedge clk);
      chk("rst_an", {24'd0, an_o}, 32'hFF);
      chk("rst_seg", {25'd0, seg_o}, 32'h7F);
      chk("rst_dp", {31'd0, dp_o}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("first_an", {24'd0, an_o}, 32'hFE);
      chk("first_seg", {25'd0, seg_o}, 32'h40);
      // 2. Scan order and dwell
      for (int i = 1; i < 40; i++) begin
         logic [7:0] a;
         @(negedge clk);
         a = ~(8'h01 << ((i / RDIV) % DIGITS));
         chk("scan_an", {24'd0, an_o}, {24'd0, a});
         chk("scan_seg", {25'd0, seg_o}, 32'h40);
      end
      // 3. Value display
      load(32'h0123_ABCF);
      for (int k = 0; k < 8; k++) check_digit(k, exp_val[k], "value");
      // 4. Leading-zero blanking
      blz = 1'b1;
      load(32'h0000_00A5);
      check_digit(0, 7'h12, "blank_d0");
      check_digit(1, 7'h08, "blank_d1");
      for (int k = 2; k < 8; k++) check_digit(k, 7'h7F, "blank_hi");
      load(32'h0);
      check_digit(0, 7'h40, "zero_d0");
      for (int k = 1; k < 8; k++) check_digit(k, 7'h7F, "zero_hi");
      blz = 1'b0;
      // 5. Tear-free update
      load(32'h0123_ABCF);
      wait_an(8'hFE, "tear_sync");
      data   = 32'hFFFF_FFFF;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      wait_an(8'h7F, "tear_d7");
      chk("tear_old", {25'd0, seg_o}, 32'h40);
      wait_an(8'hFE, "tear_next");
      chk("tear_new", {25'd0, seg_o}, 32'h0E);
      // Strobe exactly on frame_end: last cycle of digit 7 in the frame
      wait_an(8'h7F, "fe_sync");
      repeat (2) @(negedge clk);
      data   = 32'h0000_0005;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      data   = 32'hFFFF_FFFF;
      wait_an(8'hFE, "fe_next");
      chk("fe_bypass", {25'd0, seg_o}, 32'h12);
      check_digit(1, 7'h40, "fe_d1");
      // 6. Async reset mid-scan at digit 5
      wait_an(8'hDF, "arst_sync");
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_an", {24'd0, an_o}, 32'hFF);
      chk("arst_seg", {25'd0, seg_o}, 32'h7F);
      chk("arst_dp", {31'd0, dp_o}, 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_restart", {24'd0, an_o}, 32'hFE);
      chk("arst_seg0", {25'd0, seg_o}, 32'h40);
      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         update = ($urandom_range(0, 9) == 0);
         data   = $urandom >> (4 * $urandom_range(0, 8));
         if ($urandom_range(0, 49) == 0) blz = ~blz;
      end
      update = 1'b0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
